// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS instruction decode plus the ID/EX pipeline register.
// Decodes instr_id combinationally, detects load-use hazards against the
// load currently held in EX, and registers control and operands for EX.
// A bubble is the all-zero register image (SLL r0,r0,0 with no writes).
// Optional macro ID_EX_ILLEGAL_EN adds the ex_illegal output, which flags
// unknown opcode/funct encodings instead of turning them into silent bubbles.
module id_ex_stage #(
    parameter int width  = 32,
    parameter int lenght = 32,
    parameter int NB     = $clog2(lenght)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_id,
    input  logic [width-1:0] pc_plus4_id,
    input  logic [width-1:0] rs_data,
    input  logic [width-1:0] rt_data,
    input  logic             flush,
    output logic             stall_o,
    output logic [width-1:0] ex_rs_data,
    output logic [width-1:0] ex_rt_data,
    output logic [width-1:0] ex_imm,
    output logic [width-1:0] ex_pc_plus4,
    output logic [NB-1:0]    ex_rs,
    output logic [NB-1:0]    ex_rt,
    output logic [NB-1:0]    ex_write_reg,
    output logic [4:0]       ex_shamt,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic [1:0]       ex_branch,
    output logic [1:0]       ex_jump
`ifdef ID_EX_ILLEGAL_EN
    ,
    output logic             ex_illegal
`endif
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03,
                           FN_JR   = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                           FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26,
                           FN_NOR  = 6'h27, FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [width-1:0] rs_data;
        logic [width-1:0] rt_data;
        logic [width-1:0] imm;
        logic [width-1:0] pc_plus4;
        logic [NB-1:0]    rs;
        logic [NB-1:0]    rt;
        logic [NB-1:0]    write_reg;
        logic [4:0]       shamt;
        alu_op_e          alu_op;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic [1:0]       branch;
        logic [1:0]       jump;
`ifdef ID_EX_ILLEGAL_EN
        logic             illegal;
`endif
    } idex_t;

    idex_t ex_q, ex_d, dec;
    logic  known, useRs, useRt, hazard;

    logic [5:0]       opcode, funct;
    logic [NB-1:0]    rsIdx, rtIdx, rdIdx;
    logic [width-1:0] immSext, immZext, immLui, jumpTarget;

    assign opcode     = instr_id[31:26];
    assign funct      = instr_id[5:0];
    assign rsIdx      = NB'(instr_id[25:21]);
    assign rtIdx      = NB'(instr_id[20:16]);
    assign rdIdx      = NB'(instr_id[15:11]);
    assign immSext    = {{(width-16){instr_id[15]}}, instr_id[15:0]};
    assign immZext    = width'(instr_id[15:0]);
    assign immLui     = width'({instr_id[15:0], 16'h0000});
    // J/JAL carry their 26-bit target in ex_imm so EX can form the jump address
    assign jumpTarget = width'(instr_id[25:0]);

    // Decode instr_id into the EX control image and note which sources it reads
    always_comb begin
        dec          = '0;
        known        = 1'b1;
        useRs        = 1'b1;
        useRt        = 1'b0;
        dec.rs_data  = rs_data;
        dec.rt_data  = rt_data;
        dec.pc_plus4 = pc_plus4_id;
        dec.rs       = rsIdx;
        dec.rt       = rtIdx;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.write_reg = rdIdx;
                useRt         = 1'b1;
                case (funct)
                    FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_NOR:  dec.alu_op = ALU_NOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL:  begin dec.alu_op = ALU_SLL; dec.shamt = instr_id[10:6]; useRs = 1'b0; end
                    FN_SRL:  begin dec.alu_op = ALU_SRL; dec.shamt = instr_id[10:6]; useRs = 1'b0; end
                    FN_SRA:  begin dec.alu_op = ALU_SRA; dec.shamt = instr_id[10:6]; useRs = 1'b0; end
                    FN_JR: begin
                        dec.reg_write = 1'b0;
                        dec.write_reg = '0;
                        dec.jump      = 2'b11;
                        useRt         = 1'b0;
                    end
                    default: known = 1'b0;
                endcase
            end
            OP_ADDIU, OP_SLTI: begin
                dec.alu_op    = (opcode == OP_ADDIU) ? ALU_ADD : ALU_SLT;
                dec.imm       = immSext;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.write_reg = rtIdx;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                                (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                dec.imm       = immZext;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.write_reg = rtIdx;
            end
            OP_LUI: begin
                dec.alu_op    = ALU_PASSB;
                dec.imm       = immLui;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.write_reg = rtIdx;
                useRs         = 1'b0;
            end
            OP_LW: begin
                dec.imm        = immSext;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.write_reg  = rtIdx;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.imm       = immSext;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                useRt         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.alu_op = ALU_SUB;
                dec.imm    = immSext;
                dec.branch = (opcode == OP_BEQ) ? 2'b01 : 2'b10;
                useRt      = 1'b1;
            end
            OP_J: begin
                dec.imm  = jumpTarget;
                dec.jump = 2'b01;
                useRs    = 1'b0;
            end
            OP_JAL: begin
                dec.imm       = jumpTarget;
                dec.jump      = 2'b10;
                dec.reg_write = 1'b1;
                dec.write_reg = NB'(31);
                useRs         = 1'b0;
            end
            default: known = 1'b0;
        endcase
        if (!known) begin
            dec   = '0;
            useRs = 1'b0;
            useRt = 1'b0;
`ifdef ID_EX_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    // Load-use hazard detection; a flush squashes the instruction so it never stalls
    always_comb begin
        hazard  = ex_q.mem_read && (ex_q.rt != '0) &&
                  ((useRs && (rsIdx == ex_q.rt)) || (useRt && (rtIdx == ex_q.rt)));
        stall_o = hazard && !flush && !reset;
        ex_d    = dec;
        if (flush || hazard) begin
            ex_d = '0;
        end
    end

    // ID/EX pipeline register with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_rs_data    = ex_q.rs_data;
    assign ex_rt_data    = ex_q.rt_data;
    assign ex_imm        = ex_q.imm;
    assign ex_pc_plus4   = ex_q.pc_plus4;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_shamt      = ex_q.shamt;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
`ifdef ID_EX_ILLEGAL_EN
    assign ex_illegal    = ex_q.illegal;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// mnemonic-level reference model of decode, hazards, flush and reset.
// Honours ID_EX_ILLEGAL_EN when the design is built with it.
module tb_id_ex_stage;

    typedef enum {
        M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLL, M_SRL, M_SRA, M_JR,
        M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
        M_J, M_JAL, M_BAD
    } mnem_t;

    typedef struct packed {
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [4:0]  shamt;
        logic [3:0]  op;
        logic        aluSrc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [1:0]  br;
        logic [1:0]  jp;
        logic        ill;
    } exp_t;

`ifdef ID_EX_ILLEGAL_EN
    localparam bit illegalEnabled = 1'b1;
`else
    localparam bit illegalEnabled = 1'b0;
`endif

    logic        clk, reset, flush;
    logic [31:0] instr_id, pc_plus4_id, rs_data, rt_data;
    logic        stall_o;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
    logic [4:0]  ex_rs, ex_rt, ex_write_reg, ex_shamt;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [1:0]  ex_branch, ex_jump;
`ifdef ID_EX_ILLEGAL_EN
    logic        ex_illegal;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t cur;
    logic obsStall;
    logic expStall;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .pc_plus4_id(pc_plus4_id),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .stall_o(stall_o),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_write_reg(ex_write_reg), .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_jump(ex_jump)
`ifdef ID_EX_ILLEGAL_EN
        , .ex_illegal(ex_illegal)
`endif
    );

    // Free-running clock, posedge every 10 time units
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mnem_t classify(input logic [31:0] i);
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h21: return M_ADDU;  6'h23: return M_SUBU; 6'h24: return M_AND;
                6'h25: return M_OR;    6'h26: return M_XOR;  6'h27: return M_NOR;
                6'h2A: return M_SLT;   6'h00: return M_SLL;  6'h02: return M_SRL;
                6'h03: return M_SRA;   6'h08: return M_JR;
                default: return M_BAD;
            endcase
            6'h09: return M_ADDIU; 6'h0A: return M_SLTI; 6'h0C: return M_ANDI;
            6'h0D: return M_ORI;   6'h0E: return M_XORI; 6'h0F: return M_LUI;
            6'h23: return M_LW;    6'h2B: return M_SW;   6'h04: return M_BEQ;
            6'h05: return M_BNE;   6'h02: return M_J;    6'h03: return M_JAL;
            default: return M_BAD;
        endcase
    endfunction

    function automatic logic [31:0] encode(input mnem_t m, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [15:0] imm, input logic [25:0] tgt);
        case (m)
            M_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            M_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            M_AND:   return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            M_OR:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            M_XOR:   return {6'h00, rs, rt, rd, 5'd0, 6'h26};
            M_NOR:   return {6'h00, rs, rt, rd, 5'd0, 6'h27};
            M_SLT:   return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            M_SLL:   return {6'h00, 5'd0, rt, rd, sh, 6'h00};
            M_SRL:   return {6'h00, 5'd0, rt, rd, sh, 6'h02};
            M_SRA:   return {6'h00, 5'd0, rt, rd, sh, 6'h03};
            M_JR:    return {6'h00, rs, 15'd0, 6'h08};
            M_ADDIU: return {6'h09, rs, rt, imm};
            M_SLTI:  return {6'h0A, rs, rt, imm};
            M_ANDI:  return {6'h0C, rs, rt, imm};
            M_ORI:   return {6'h0D, rs, rt, imm};
            M_XORI:  return {6'h0E, rs, rt, imm};
            M_LUI:   return {6'h0F, 5'd0, rt, imm};
            M_LW:    return {6'h23, rs, rt, imm};
            M_SW:    return {6'h2B, rs, rt, imm};
            M_BEQ:   return {6'h04, rs, rt, imm};
            M_BNE:   return {6'h05, rs, rt, imm};
            M_J:     return {6'h02, tgt};
            M_JAL:   return {6'h03, tgt};
            default: return {6'h3F, tgt};
        endcase
    endfunction

    function automatic logic usesRs(input mnem_t m);
        return !(m inside {M_J, M_JAL, M_LUI, M_SLL, M_SRL, M_SRA, M_BAD});
    endfunction

    function automatic logic usesRt(input mnem_t m);
        return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT,
                         M_SLL, M_SRL, M_SRA, M_SW, M_BEQ, M_BNE};
    endfunction

    // What EX should hold after this instruction is accepted from ID
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] rsd,
                                   input logic [31:0] rtd, input logic [31:0] pc);
        exp_t  e;
        mnem_t m;
        m = classify(i);
        e = '0;
        if (m == M_BAD) begin
            e.ill = illegalEnabled;
            return e;
        end
        e.rsData = rsd;
        e.rtData = rtd;
        e.pc     = pc;
        e.rs     = i[25:21];
        e.rt     = i[20:16];
        case (m)
            M_SUBU, M_BEQ, M_BNE: e.op = 4'd1;
            M_AND, M_ANDI:        e.op = 4'd2;
            M_OR, M_ORI:          e.op = 4'd3;
            M_XOR, M_XORI:        e.op = 4'd4;
            M_NOR:                e.op = 4'd5;
            M_SLT, M_SLTI:        e.op = 4'd6;
            M_SLL:                e.op = 4'd7;
            M_SRL:                e.op = 4'd8;
            M_SRA:                e.op = 4'd9;
            M_LUI:                e.op = 4'd10;
            default:              e.op = 4'd0;
        endcase
        if (m inside {M_ADDIU, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE}) e.imm = {{16{i[15]}}, i[15:0]};
        else if (m inside {M_ANDI, M_ORI, M_XORI})               e.imm = {16'h0000, i[15:0]};
        else if (m == M_LUI)                                     e.imm = {i[15:0], 16'h0000};
        else if (m inside {M_J, M_JAL})                          e.imm = {6'd0, i[25:0]};
        e.aluSrc = m inside {M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW};
        if (m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLL, M_SRL, M_SRA}) begin
            e.rw = 1'b1;
            e.wr = i[15:11];
        end else if (m inside {M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW}) begin
            e.rw = 1'b1;
            e.wr = i[20:16];
        end else if (m == M_JAL) begin
            e.rw = 1'b1;
            e.wr = 5'd31;
        end
        if (m inside {M_SLL, M_SRL, M_SRA}) e.shamt = i[10:6];
        e.mr  = (m == M_LW);
        e.m2r = (m == M_LW);
        e.mw  = (m == M_SW);
        e.br  = (m == M_BEQ) ? 2'b01 : (m == M_BNE) ? 2'b10 : 2'b00;
        e.jp  = (m == M_J) ? 2'b01 : (m == M_JAL) ? 2'b10 : (m == M_JR) ? 2'b11 : 2'b00;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".rs_data"},    ex_rs_data,            cur.rsData);
        chk({tag, ".rt_data"},    ex_rt_data,            cur.rtData);
        chk({tag, ".imm"},        ex_imm,                cur.imm);
        chk({tag, ".pc_plus4"},   ex_pc_plus4,           cur.pc);
        chk({tag, ".rs"},         32'(ex_rs),            32'(cur.rs));
        chk({tag, ".rt"},         32'(ex_rt),            32'(cur.rt));
        chk({tag, ".write_reg"},  32'(ex_write_reg),     32'(cur.wr));
        chk({tag, ".shamt"},      32'(ex_shamt),         32'(cur.shamt));
        chk({tag, ".alu_op"},     32'(ex_alu_op),        32'(cur.op));
        chk({tag, ".alu_src"},    32'(ex_alu_src),       32'(cur.aluSrc));
        chk({tag, ".reg_write"},  32'(ex_reg_write),     32'(cur.rw));
        chk({tag, ".mem_read"},   32'(ex_mem_read),      32'(cur.mr));
        chk({tag, ".mem_write"},  32'(ex_mem_write),     32'(cur.mw));
        chk({tag, ".mem_to_reg"}, 32'(ex_mem_to_reg),    32'(cur.m2r));
        chk({tag, ".branch"},     32'(ex_branch),        32'(cur.br));
        chk({tag, ".jump"},       32'(ex_jump),          32'(cur.jp));
`ifdef ID_EX_ILLEGAL_EN
        chk({tag, ".illegal"},    32'(ex_illegal),       32'(cur.ill));
`endif
    endtask

    // Drive one ID cycle, check stall before the edge and the EX register after it
    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] rsd, input logic [31:0] rtd,
                                 input logic [31:0] pc, input logic fl, input logic rst,
                                 input string tag);
        mnem_t m;
        exp_t  nxt;
        @(negedge clk);
        instr_id    = i;
        rs_data     = rsd;
        rt_data     = rtd;
        pc_plus4_id = pc;
        flush       = fl;
        reset       = rst;
        #1;
        m        = classify(i);
        expStall = !rst && !fl && cur.mr && (cur.rt != 5'd0) &&
                   ((usesRs(m) && (i[25:21] == cur.rt)) || (usesRt(m) && (i[20:16] == cur.rt)));
        obsStall = stall_o;
        chk({tag, ".stall_o"}, 32'(stall_o), 32'(expStall));
        nxt = (rst || fl || expStall) ? exp_t'('0) : model(i, rsd, rtd, pc);
        @(posedge clk);
        #1;
        cur = nxt;
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] rInstr, rRs, rRt, rPc;
        mnem_t       rm;
        logic        rFl, rRst;

        reset = 1'b1; flush = 1'b0; instr_id = '0; pc_plus4_id = '0; rs_data = '0; rt_data = '0;
        cur = '0;
        expStall = 1'b0;
        $display("[TB] start");

        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "reset0");
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "reset1");
        chk("reset.stall_o", 32'(obsStall), 32'd0);
        chk("reset.reg_write", 32'(ex_reg_write), 32'd0);

        applyStimulus(32'h00221821, 32'd5, 32'd7, 32'h104, 1'b0, 1'b0, "addu");
        chk("addu.alu_op_k",    32'(ex_alu_op),    32'd0);
        chk("addu.write_reg_k", 32'(ex_write_reg), 32'd3);
        chk("addu.reg_write_k", 32'(ex_reg_write), 32'd1);
        chk("addu.rs_data_k",   ex_rs_data,        32'd5);
        chk("addu.rt_data_k",   ex_rt_data,        32'd7);

        applyStimulus(32'h8C220004, 32'h11, 32'h22, 32'h108, 1'b0, 1'b0, "lw");
        chk("lw.mem_read_k", 32'(ex_mem_read), 32'd1);
        applyStimulus(32'h00441821, 32'h33, 32'h44, 32'h10C, 1'b0, 1'b0, "lu_stall");
        chk("lu_stall.stall_k",  32'(obsStall),     32'd1);
        chk("lu_stall.bubble_k", 32'(ex_reg_write), 32'd0);
        applyStimulus(32'h00441821, 32'h33, 32'h44, 32'h10C, 1'b0, 1'b0, "lu_replay");
        chk("lu_replay.stall_k", 32'(obsStall),     32'd0);
        chk("lu_replay.wr_k",    32'(ex_write_reg), 32'd3);
        chk("lu_replay.rs_k",    32'(ex_rs),        32'd2);

        applyStimulus(32'h2405FFFF, 32'h0, 32'h0, 32'h110, 1'b0, 1'b0, "addiu");
        chk("addiu.imm_k",     ex_imm,          32'hFFFFFFFF);
        chk("addiu.alu_src_k", 32'(ex_alu_src), 32'd1);
        applyStimulus(32'h3405FFFF, 32'h0, 32'h0, 32'h114, 1'b0, 1'b0, "ori");
        chk("ori.imm_k", ex_imm, 32'h0000FFFF);
        applyStimulus(32'h3C051234, 32'h0, 32'h0, 32'h118, 1'b0, 1'b0, "lui");
        chk("lui.imm_k",    ex_imm,         32'h12340000);
        chk("lui.alu_op_k", 32'(ex_alu_op), 32'd10);

        applyStimulus(32'h8C220004, 32'h1, 32'h2, 32'h11C, 1'b0, 1'b0, "lw2");
        applyStimulus(32'h00441821, 32'h5, 32'h6, 32'h120, 1'b1, 1'b0, "flush_hz");
        chk("flush_hz.stall_k",  32'(obsStall),     32'd0);
        chk("flush_hz.bubble_k", 32'(ex_reg_write), 32'd0);
        applyStimulus(32'h0C000010, 32'h0, 32'h0, 32'h200, 1'b0, 1'b0, "jal");
        chk("jal.wr_k",   32'(ex_write_reg), 32'd31);
        chk("jal.jump_k", 32'(ex_jump),      32'd2);

        applyStimulus(32'hFC000000, 32'h9, 32'h9, 32'h204, 1'b0, 1'b0, "bad");
        chk("bad.reg_write_k", 32'(ex_reg_write), 32'd0);
`ifdef ID_EX_ILLEGAL_EN
        chk("bad.illegal_k", 32'(ex_illegal), 32'd1);
`endif
        applyStimulus(32'h00221821, 32'd5, 32'd7, 32'h208, 1'b0, 1'b0, "after_bad");
`ifdef ID_EX_ILLEGAL_EN
        chk("after_bad.illegal_k", 32'(ex_illegal), 32'd0);
`endif

        // Random program; a stalled instruction is re-presented as IF/ID would hold it
        rInstr = 32'h0; rRs = 32'h0; rRt = 32'h0; rPc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            if (!expStall) begin
                rm = mnem_t'($urandom_range(0, 23));
                if ($urandom_range(0, 3) == 0) rm = M_LW;
                rInstr = encode(rm, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                                16'($urandom), 26'($urandom));
                rRs = $urandom;
                rRt = $urandom;
                rPc = rPc + 32'd4;
            end
            rFl  = ($urandom_range(0, 9) == 0);
            rRst = ($urandom_range(0, 99) == 0);
            applyStimulus(rInstr, rRs, rRt, rPc, rFl, rRst, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
